// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Shift-and-add multiplier that borrows the shared 32-bit combinational ALU.
// Every arithmetic step is done by the external ALU: this block only drives
// the ALU operands/opcode for the current state and latches the ALU result
// on the same rising edge. The result is the low 32 bits of req_a * req_b.
//
// One iteration processes one multiplier bit:
//   TEST -> (ADD if B[0]) -> SHL -> SHR -> TEST ...
// TEST finishes the operation once the multiplier is exhausted (B == 0, taken
// from the ALU equality flag) or after MAX_ITER shift steps.

module alu_mul_sequencer #(
    parameter int MAX_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    // response channel
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] product,
    output logic        busy,
    // shared ALU
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    // ALU opcodes used by the sequencer
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SHL  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;

    // Step limit compared against the 6-bit shift counter
    localparam logic [5:0] MAX_CNT = 6'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] a_q,       a_d;
    logic [31:0] b_q,       b_d;
    logic [31:0] acc_q,     acc_d;
    logic [5:0]  cnt_q,     cnt_d;
    logic [31:0] product_q, product_d;

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next state and register updates; ALU results are captured in the state that issued them
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone completes the handshake
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                // alu_zero compares B against 0 in this state
                if (alu_zero || (cnt_q == MAX_CNT)) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else if (b_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_ADD: begin
                // 32-bit wrap: the ALU carry is simply not kept
                acc_d   = alu_out;
                state_d = S_SHL;
            end
            S_SHL: begin
                a_d     = alu_out;
                state_d = S_SHR;
            end
            S_SHR: begin
                b_d     = alu_out;
                cnt_d   = cnt_q + 6'd1;
                state_d = S_TEST;
            end
            S_DONE: begin
                // product_q is only written in TEST, so it stays put while the consumer stalls
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU drive and handshake outputs, decoded purely from the current state and registers
    always_comb begin
        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = ALU_PASS;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        busy        = 1'b1;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_TEST: begin
                alu_in1 = b_q;
            end
            S_ADD: begin
                alu_in1     = acc_q;
                alu_in2     = a_q;
                alu_control = ALU_ADD;
            end
            S_SHL: begin
                alu_in1     = a_q;
                alu_in2     = 32'd1;
                alu_control = ALU_SHL;
            end
            S_SHR: begin
                alu_in1     = b_q;
                alu_in2     = 32'd1;
                alu_control = ALU_SHR;
            end
            S_DONE: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
// Drives alu_mul_sequencer with a behavioural model of the shared ALU attached
// and compares products, latencies and handshake behaviour against values
// computed here from plain arithmetic.

module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] product;
    logic        busy;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    // alu_control values observed each busy cycle of the most recent operation
    logic [2:0] ctrl_trace[$];

    alu_mul_sequencer #(.MAX_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .product    (product),
        .busy       (busy),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_control(alu_control),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero)
    );

    // 100 MHz-style clock
    always #5 clk = ~clk;

    // Shared combinational ALU as seen by the sequencer
    function automatic logic [31:0] alu_model(input logic [31:0] in1, input logic [31:0] in2,
                                              input logic [2:0] ctrl);
        case (ctrl)
            3'b000:  return in1 + in2;
            3'b100:  return in1 << in2;
            3'b101:  return in1 >> in2;
            default: return in1;
        endcase
    endfunction

    assign alu_out  = alu_model(alu_in1, alu_in2, alu_control);
    assign alu_zero = (alu_in1 == alu_in2);

    // Cycles from the accept cycle (counted as cycle 1) to the first cycle with resp_valid:
    // two fixed cycles plus 3 per multiplier bit up to the top set bit and one more per set bit
    function automatic int expected_latency(input logic [31:0] b);
        int iters;
        int ones;
        iters = 0;
        ones  = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                ones++;
                iters = i + 1;
            end
        end
        return 2 + 3 * iters + ones;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Run one complete multiply: request, wait for the response, optional consumer stall, release.
    // With noise set, junk requests and stray resp_ready pulses are thrown at the busy block.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int stall, input bit noise);
        int          lat;
        int          guard;
        bit          ready_seen;
        logic [31:0] exp_product;
        exp_product = a * b;

        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);

        tick();
        req_valid = 1'b0;
        ctrl_trace.delete();
        lat        = 1;
        ready_seen = 1'b0;
        while (resp_valid !== 1'b1 && lat < 200) begin
            ctrl_trace.push_back(alu_control);
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            if (noise) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_a      = $urandom;
                req_b      = $urandom;
                resp_ready = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        resp_ready = 1'b0;
        checkOutput("resp_latency", 32'(lat), 32'(expected_latency(b)));
        checkOutput("req_ready_while_busy", {31'b0, ready_seen}, 32'd0);

        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                req_valid = 1'b1;
                req_a     = $urandom;
                req_b     = $urandom;
            end
            tick();
        end
        checkOutput("product", product, exp_product);
        checkOutput("done_hold", {29'b0, resp_valid, req_ready, busy}, {29'b0, 3'b101});

        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("release_idle", {29'b0, resp_valid, req_ready, busy}, {29'b0, 3'b010});
    endtask

    // Directed scenarios followed by the randomized soak
    initial begin
        logic [2:0]  exp_trace[12];
        int          non_pass;
        bit          resp_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_outputs", {28'b0, req_ready, busy, resp_valid, 1'b0},
                    {28'b0, 4'b1000});
        checkOutput("reset_alu_ctrl", {29'b0, alu_control}, 32'd7);
        checkOutput("reset_product", product, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 3 x 5 with the exact ALU op sequence
        applyStimulus(32'd3, 32'd5, 0, 1'b0);
        exp_trace = '{3'b111, 3'b000, 3'b100, 3'b101, 3'b111, 3'b100,
                      3'b101, 3'b111, 3'b000, 3'b100, 3'b101, 3'b111};
        checkOutput("trace_len_3x5", 32'(ctrl_trace.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < ctrl_trace.size())
                checkOutput($sformatf("trace_3x5[%0d]", i), {29'b0, ctrl_trace[i]}, {29'b0, exp_trace[i]});
        end

        // Zero multiplier: straight to DONE, no arithmetic ops
        applyStimulus(32'h0000_1234, 32'd0, 0, 1'b0);
        non_pass = 0;
        foreach (ctrl_trace[i]) if (ctrl_trace[i] != 3'b111) non_pass++;
        checkOutput("b0_no_alu_ops", 32'(non_pass), 32'd0);

        // Zero multiplicand, wrap-around cases and worst-case latency
        applyStimulus(32'd0, 32'h0000_00A5, 0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 0, 1'b0);

        // Consumer stalls 10 cycles in DONE while new requests are offered, then a second op
        applyStimulus(32'd6, 32'd7, 10, 1'b1);
        applyStimulus(32'd9, 32'd11, 0, 1'b0);

        // Asynchronous reset while in SHL: TEST, ADD, then SHL for 7 x 3
        req_a     = 32'd7;
        req_b     = 32'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("pre_reset_in_shl", {29'b0, alu_control}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", {28'b0, busy, req_ready, resp_valid, 1'b0},
                    {28'b0, 4'b0100});
        checkOutput("async_reset_alu_ctrl", {29'b0, alu_control}, 32'd7);
        checkOutput("async_reset_product", product, 32'd0);
        tick();
        rst = 1'b0;
        resp_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid !== 1'b0 || busy !== 1'b0) resp_seen = 1'b1;
            tick();
        end
        checkOutput("aborted_no_response", {31'b0, resp_seen}, 32'd0);
        applyStimulus(32'd12, 32'd13, 0, 1'b0);

        // Random operands of varying multiplier length, back-to-back, with stalls and noise
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (n % 50 == 0) rb = $urandom;
            applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
